seq_stim_gen: RTL and testbench

- Synthesizable stimulus generator that drives an x/y handshake pair with the timing relation "x, then y exactly DELAY cycles later", ready for a concurrent-assertion checker.
- It is the driving end of the pattern our `x ##N y |-> x && y` style checkers observe.
- Each window is either legal (x still high when y rises, so the consequent holds) or deliberately illegal (x dropped at the y cycle, so the checker must fire).
- Sits in the testbench/DV infrastructure; the outputs are registered so checkers sample clean values.

---
 rtl/seq_stim_pkg.sv | 24 ++
 rtl/seq_stim_dncnt.sv | 29 ++
 rtl/seq_stim_gen.sv | 153 +++++++++++++++
 tb/tb_seq_stim_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_stim_pkg.sv
// seq_stim_gen shared types
// state encoding, default widths, latched run config
package seq_stim_pkg;

  localparam int DLY_W_D = 4;
  localparam int GAP_W_D = 4;
  localparam int REP_W_D = 8;

  typedef enum logic [2:0] {
    IDLE,
    X_PH,
    XY_PH,
    GAP_PH,
    DONE
  } state_t;

  typedef struct packed {
    logic [DLY_W_D-1:0] delay;
    logic [GAP_W_D-1:0] gap;
    logic [REP_W_D-1:0] reps;
    logic               legal;
  } cfg_t;

endpackage

// File: rtl/seq_stim_dncnt.sv
// seq_stim_gen loadable down-counter
// holds at zero, load wins over en
module seq_stim_dncnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // count register: load, else decrement while nonzero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/seq_stim_gen.sv
// seq_stim_gen top: x then y DELAY cycles later
// outputs registered off next state
module seq_stim_gen
  import seq_stim_pkg::*;
#(
  parameter int DLY_W = DLY_W_D,
  parameter int GAP_W = GAP_W_D,
  parameter int REP_W = REP_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DLY_W-1:0] delay,
  input  logic [GAP_W-1:0] gap,
  input  logic [REP_W-1:0] reps,
  input  logic             legal,
  output logic             x_o,
  output logic             y_o,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] win_cnt
);

  state_t state, state_nx;
  cfg_t   cfg, cfg_nx;

  logic [REP_W-1:0] win_nx;
  logic [REP_W:0]   win_p1;
  logic             last;

  logic             dly_load, dly_en, dly_zero;
  logic [DLY_W-1:0] dly_val;
  logic             gap_load, gap_en, gap_zero;
  logic [GAP_W-1:0] gap_val;

  logic x_nx, y_nx, busy_nx, done_nx;

  seq_stim_dncnt #(.W(DLY_W)) u_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dly_load),
    .en       (dly_en),
    .load_val (dly_val),
    .zero     (dly_zero)
  );

  seq_stim_dncnt #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .en       (gap_en),
    .load_val (gap_val),
    .zero     (gap_zero)
  );

  assign win_p1 = {1'b0, win_cnt} + (REP_W+1)'(1);
  assign last   = (win_p1 >= {1'b0, cfg.reps});

  // state, config and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cfg     <= '0;
      win_cnt <= '0;
      x_o     <= 1'b0;
      y_o     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      cfg     <= cfg_nx;
      win_cnt <= win_nx;
      x_o     <= x_nx;
      y_o     <= y_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

  // next state, counter control and next outputs
  always_comb begin
    state_nx = state;
    cfg_nx   = cfg;
    win_nx   = win_cnt;
    dly_load = 1'b0;
    dly_en   = 1'b0;
    dly_val  = '0;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    gap_val  = '0;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cfg_nx = '{delay, gap, reps, legal};
            win_nx = '0;
            if (reps == '0) begin
              state_nx = DONE;
            end else if (delay == '0) begin
              state_nx = XY_PH;
            end else begin
              state_nx = X_PH;
              dly_load = 1'b1;
              dly_val  = delay - DLY_W'(1);
            end
          end
        end
        X_PH: begin
          if (dly_zero) state_nx = XY_PH;
          else          dly_en   = 1'b1;
        end
        XY_PH: begin
          if (win_cnt != '1) win_nx = win_cnt + REP_W'(1);
          if (last) begin
            state_nx = DONE;
          end else if (cfg.gap != '0) begin
            state_nx = GAP_PH;
            gap_load = 1'b1;
            gap_val  = cfg.gap - GAP_W'(1);
          end else if (cfg.delay == '0) begin
            state_nx = XY_PH;
          end else begin
            state_nx = X_PH;
            dly_load = 1'b1;
            dly_val  = cfg.delay - DLY_W'(1);
          end
        end
        GAP_PH: begin
          if (!gap_zero) begin
            gap_en = 1'b1;
          end else if (cfg.delay == '0) begin
            state_nx = XY_PH;
          end else begin
            state_nx = X_PH;
            dly_load = 1'b1;
            dly_val  = cfg.delay - DLY_W'(1);
          end
        end
        DONE: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
    y_nx    = (state_nx == XY_PH);
    x_nx    = (state_nx == X_PH) ||
              (y_nx && (cfg_nx.legal || cfg_nx.delay == '0));
    busy_nx = (state_nx != IDLE) && (state_nx != DONE);
    done_nx = (state_nx == DONE);
  end

endmodule

// File: tb/tb_seq_stim_gen.sv
// seq_stim_gen directed bench
// samples 1ns after each rising edge
module tb_seq_stim_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] delay = '0;
  logic [3:0] gap = '0;
  logic [7:0] reps = '0;
  logic       legal = 1'b0;
  logic       x_o, y_o, busy, done;
  logic [7:0] win_cnt;

  int tests = 0;
  int fails = 0;
  int viol = 0;

  seq_stim_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .delay   (delay),
    .gap     (gap),
    .reps    (reps),
    .legal   (legal),
    .x_o     (x_o),
    .y_o     (y_o),
    .busy    (busy),
    .done    (done),
    .win_cnt (win_cnt)
  );

  always #5 clk = ~clk;

  // x ##N y |-> x && y observer: y without x is a violation
  always @(negedge clk)
    if (rst_n && y_o && !x_o) viol++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // outputs {x,y,busy,done}
  task automatic chk_o(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, x_o, y_o, busy, done}, {28'd0, exp});
  endtask

  task automatic go(input logic [3:0] d, input logic [3:0] g,
                    input logic [7:0] r, input logic l);
    delay = d;
    gap   = g;
    reps  = r;
    legal = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int v0;

  initial begin
    #3;
    chk_o("rst_out", 4'b0000);
    chk("rst_win", win_cnt, 0);
    step();
    rst_n = 1'b1;
    step();

    // legal window, delay 5
    v0 = viol;
    go(4'd5, 4'd2, 8'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk_o($sformatf("t1_x%0d", i), 4'b1010);
      step();
    end
    chk_o("t1_xy", 4'b1110);
    step();
    chk_o("t1_done", 4'b0001);
    chk("t1_win", win_cnt, 1);
    step();
    chk_o("t1_idle", 4'b0000);
    chk("t1_viol", viol - v0, 0);

    // illegal window, delay 5
    v0 = viol;
    go(4'd5, 4'd2, 8'd1, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk_o("t2_y_nox", 4'b0110);
    step();
    chk_o("t2_done", 4'b0001);
    step();
    chk("t2_viol", viol - v0, 1);

    // ##0 back-to-back, legal ignored
    v0 = viol;
    go(4'd0, 4'd0, 8'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk_o($sformatf("t3_xy%0d", i), 4'b1110);
      step();
    end
    chk_o("t3_done", 4'b0001);
    chk("t3_win", win_cnt, 3);
    chk("t3_viol", viol - v0, 0);
    step();

    // reps 0
    go(4'd3, 4'd1, 8'd0, 1'b1);
    chk_o("t4_done", 4'b0001);
    chk("t4_win", win_cnt, 0);
    step();
    chk_o("t4_idle", 4'b0000);

    // abort wins over start in IDLE
    abort = 1'b1;
    go(4'd3, 4'd1, 8'd2, 1'b1);
    abort = 1'b0;
    chk_o("t5_abst", 4'b0000);
    step();
    chk_o("t5_abst2", 4'b0000);

    // abort during second window X_PH
    go(4'd3, 4'd4, 8'd4, 1'b1);
    step();
    step();
    step();
    chk_o("t6_xy1", 4'b1110);
    step();
    chk_o("t6_gap", 4'b0010);
    chk("t6_win1", win_cnt, 1);
    for (int i = 0; i < 4; i++) step();
    chk_o("t6_x2", 4'b1010);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_o("t6_abort", 4'b0000);
    chk("t6_winh", win_cnt, 1);
    step();
    chk_o("t6_nodone", 4'b0000);

    // clean restart after abort
    go(4'd1, 4'd0, 8'd2, 1'b1);
    chk("t7_win0", win_cnt, 0);
    chk_o("t7_x", 4'b1010);
    step();
    chk_o("t7_xy", 4'b1110);
    step();
    chk_o("t7_x2", 4'b1010);
    step();
    chk_o("t7_xy2", 4'b1110);
    step();
    chk_o("t7_done", 4'b0001);
    chk("t7_win", win_cnt, 2);
    step();

    // async reset during XY_PH
    go(4'd2, 4'd1, 8'd2, 1'b1);
    step();
    step();
    chk_o("t8_xy", 4'b1110);
    #1;
    rst_n = 1'b0;
    #1;
    chk_o("t8_rst", 4'b0000);
    chk("t8_win", win_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // start while busy is ignored
    go(4'd2, 4'd1, 8'd2, 1'b1);
    reps  = 8'd5;
    delay = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk_o("t9_xy1", 4'b1110);
    step();
    chk_o("t9_gap", 4'b0010);
    step();
    step();
    chk_o("t9_x2", 4'b1010);
    step();
    chk_o("t9_xy2", 4'b1110);
    step();
    chk_o("t9_done", 4'b0001);
    chk("t9_win", win_cnt, 2);
    step();
    chk_o("t9_idle", 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
